tt_probe: RTL and testbench

- Sequential truth-table characterizer: the reading end of a combinational logic-gate block.
- Sweeps all 2**N_IN input combinations into a gate under test and samples its single output after a programmable settle time.
- Assembles the measured truth table in the team's hex-rule encoding and compares it against an expected table.
- Sits beside any compiled gate-level circuit module for in-sim or on-FPGA characterization.

---
 rtl/tt_probe_pkg.sv | 15 +
 rtl/tt_settle_sampler.sv | 46 ++++
 rtl/tt_probe.sv | 116 +++++++++++
 tb/tb_tt_probe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_probe_pkg.sv
// Shared types and helpers for the truth-table probe and its checkers.
package tt_probe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } tt_state_e;

  // Row k lands in bit 2**n_in-1-k, so row 0 is the table MSB.
  function automatic int tt_index(input int row, input int n_in);
    return (1 << n_in) - 1 - row;
  endfunction

endpackage

// File: rtl/tt_settle_sampler.sv
// Holds one probe vector for SETTLE cycles and strobes the sample on the last one,
// flagging the row unstable if the output moved between the last two cycles.
module tt_settle_sampler #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic probe_out,
  output logic sample,
  output logic unstable
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [SW-1:0] settle_q, settle_d;
  logic          prev_q, prev_d;
  logic          last;

  assign last     = (settle_q == SW'(SETTLE - 1));
  assign sample   = en & last;
  assign unstable = probe_out ^ prev_q;

  always_comb begin
    settle_d = settle_q;
    prev_d   = prev_q;
    if (clr) begin
      settle_d = '0;
    end else if (en) begin
      settle_d = last ? '0 : settle_q + 1'b1;
      if (settle_q == SW'(SETTLE - 2)) prev_d = probe_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q <= '0;
      prev_q   <= 1'b0;
    end else begin
      settle_q <= settle_d;
      prev_q   <= prev_d;
    end
  end

endmodule

// File: rtl/tt_probe.sv
// Truth-table characterizer: sweeps every input vector into a gate, samples its
// output after SETTLE cycles and compares the assembled table to a reference.
module tt_probe
  import tt_probe_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        probe_in,
  input  logic                   probe_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   match,
  output logic [(1<<N_IN)-1:0]   mismatch,
  output logic [(1<<N_IN)-1:0]   unstable
);

  localparam int W = 1 << N_IN;

  tt_state_e         state_q, state_d;
  logic [N_IN-1:0]   row_q, row_d;
  logic [W-1:0]      exp_q, exp_d;
  logic [W-1:0]      table_q, table_d;
  logic [W-1:0]      unst_q, unst_d;
  logic [W-1:0]      mism_q, mism_d;
  logic              match_q, match_d;
  logic              accept, sample, row_unstable;
  logic [N_IN-1:0]   idx;

  assign accept = (state_q == IDLE) && start;
  assign idx    = N_IN'(tt_index(int'(row_q), N_IN));

  tt_settle_sampler #(.SETTLE(SETTLE)) u_sampler (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept),
    .en        (state_q == DRIVE),
    .probe_out (probe_out),
    .sample    (sample),
    .unstable  (row_unstable)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    exp_d   = exp_q;
    table_d = table_q;
    unst_d  = unst_q;
    mism_d  = mism_q;
    match_d = match_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected;
          table_d = '0;
          unst_d  = '0;
          mism_d  = '0;
          match_d = 1'b0;
          row_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (sample) begin
          table_d[idx] = probe_out;
          unst_d[idx]  = row_unstable;
          if (&row_q) begin
            // Compare against the table including this final sample so the
            // verdict is ready in the DONE cycle.
            match_d = (table_d == exp_q);
            mism_d  = table_d ^ exp_q;
            state_d = DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      unst_q  <= '0;
      mism_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      unst_q  <= unst_d;
      mism_q  <= mism_d;
      match_q <= match_d;
    end
  end

  assign busy      = (state_q == DRIVE);
  assign done      = (state_q == DONE);
  assign probe_in  = busy ? row_q : '0;
  assign table_out = table_q;
  assign match     = match_q;
  assign mismatch  = mism_q;
  assign unstable  = unst_q;

endmodule

// File: tb/tb_tt_probe.sv
// Directed bench for tt_probe: default 3-input instance plus a 2-input, SETTLE=2 instance.
module tb_tt_probe;
  import tt_probe_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] expected = 8'h00;
  logic [2:0] probe_in;
  logic       probe_out;
  logic       busy, done, match;
  logic [7:0] table_out, mismatch, unstable;

  logic       start2 = 1'b0;
  logic [3:0] expected2 = 4'h0;
  logic [1:0] probe_in2;
  logic       probe_out2;
  logic       busy2, done2, match2;
  logic [3:0] table_out2, mismatch2, unstable2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int mode  = 0;
  int cnt3  = 0;
  logic [7:0] rule_eb = 8'hEB;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate models: 0 = rule 0xEB, 1 = const 1, 2 = const 0, 3 = 0xEB with row 3 glitching late
  always @(posedge clk) begin
    if (!busy) cnt3 <= 0;
    else if (probe_in == 3'd3) cnt3 <= cnt3 + 1;
  end

  always_comb begin
    probe_out = rule_eb[tt_index(int'(probe_in), 3)];
    case (mode)
      1: probe_out = 1'b1;
      2: probe_out = 1'b0;
      3: if (probe_in == 3'd3) probe_out = (cnt3 < 3);
      default: ;
    endcase
  end

  assign probe_out2 = &probe_in2;

  tt_probe #(.N_IN(3), .SETTLE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .expected(expected),
    .probe_in(probe_in), .probe_out(probe_out), .busy(busy), .done(done),
    .table_out(table_out), .match(match), .mismatch(mismatch), .unstable(unstable)
  );

  tt_probe #(.N_IN(2), .SETTLE(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .expected(expected2),
    .probe_in(probe_in2), .probe_out(probe_out2), .busy(busy2), .done(done2),
    .table_out(table_out2), .match(match2), .mismatch(mismatch2), .unstable(unstable2)
  );

  // Stimulus only: returns latency (start cycle to done cycle), busy cycle count and
  // number of cycles where probe_in did not follow the 4-cycle staircase.
  task automatic do_sweep(input logic [7:0] exp, output int lat, output int busy_n,
                          output int step_err);
    int s;
    lat = -1; busy_n = 0; step_err = 0;
    expected = exp;
    start = 1'b1;
    s = cyc;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) begin
        busy_n++;
        if (probe_in !== 3'((cyc - s - 1) / 4)) step_err++;
      end
      if (done) begin
        lat = cyc - s;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (probe_in !== 3'd0) begin n_err++; $display("FAIL reset_probe got %0d want 0", probe_in); end
    n_cmp++; if ({table_out, mismatch, unstable, match} !== 25'd0) begin
      n_err++; $display("FAIL reset_outs got tbl=%h mis=%h uns=%h m=%b want all 0", table_out, mismatch, unstable, match);
    end
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_start_wins got busy=%b want 0", busy); end
  endtask

  task automatic test_eb_match();
    int lat, bn, se;
    mode = 0;
    do_sweep(8'hEB, lat, bn, se);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL eb_latency got %0d want 33", lat); end
    n_cmp++; if (bn !== 32) begin n_err++; $display("FAIL eb_busy_cycles got %0d want 32", bn); end
    n_cmp++; if (se !== 0) begin n_err++; $display("FAIL eb_probe_steps got %0d bad cycles want 0", se); end
    n_cmp++; if (table_out !== 8'hEB) begin n_err++; $display("FAIL eb_table got %h want eb", table_out); end
    n_cmp++; if (match !== 1'b1) begin n_err++; $display("FAIL eb_match got %b want 1", match); end
    n_cmp++; if (mismatch !== 8'h00) begin n_err++; $display("FAIL eb_mismatch got %h want 00", mismatch); end
    n_cmp++; if (unstable !== 8'h00) begin n_err++; $display("FAIL eb_unstable got %h want 00", unstable); end
    // start during DONE is ignored; verdict holds
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL done_start_ignored got busy=%b done=%b want 0 0", busy, done);
    end
    n_cmp++; if (match !== 1'b1 || probe_in !== 3'd0) begin
      n_err++; $display("FAIL match_held got match=%b probe=%0d want 1 0", match, probe_in);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_eb_mismatch();
    int lat, bn, se;
    mode = 0;
    do_sweep(8'hD7, lat, bn, se);
    n_cmp++; if (table_out !== 8'hEB) begin n_err++; $display("FAIL d7_table got %h want eb", table_out); end
    n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL d7_match got %b want 0", match); end
    n_cmp++; if (mismatch !== 8'h3C) begin n_err++; $display("FAIL d7_mismatch got %h want 3c", mismatch); end
    @(posedge clk); #1;
  endtask

  task automatic test_constants();
    int lat, bn, se;
    mode = 1;
    do_sweep(8'hFF, lat, bn, se);
    n_cmp++; if (table_out !== 8'hFF) begin n_err++; $display("FAIL const1_table got %h want ff", table_out); end
    n_cmp++; if (bn !== 32) begin n_err++; $display("FAIL const1_busy got %0d want 32", bn); end
    @(posedge clk); #1;
    mode = 2;
    do_sweep(8'hFF, lat, bn, se);
    n_cmp++; if (table_out !== 8'h00) begin n_err++; $display("FAIL const0_table got %h want 00", table_out); end
    n_cmp++; if (bn !== 32) begin n_err++; $display("FAIL const0_busy got %0d want 32", bn); end
    n_cmp++; if (match !== 1'b0 || mismatch !== 8'hFF) begin
      n_err++; $display("FAIL const0_cmp got match=%b mis=%h want 0 ff", match, mismatch);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, bn, se, dn;
    mode = 0;
    expected = 8'hEB;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      start = (i == 4 || i == 6);
    end
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || probe_in !== 3'd2) begin
      n_err++; $display("FAIL mid_start_ignored got busy=%b probe=%0d want 1 2", busy, probe_in);
    end
    n_cmp++; if (table_out !== 8'hC0) begin n_err++; $display("FAIL mid_partial_table got %h want c0", table_out); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0 || probe_in !== 3'd0 || table_out !== 8'h00 || done !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got busy=%b probe=%0d tbl=%h done=%b want 0 0 00 0", busy, probe_in, table_out, done);
    end
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) dn++;
    end
    n_cmp++; if (dn !== 0) begin n_err++; $display("FAIL mid_no_done got %0d active cycles want 0", dn); end
    do_sweep(8'hEB, lat, bn, se);
    n_cmp++; if (lat !== 33 || table_out !== 8'hEB || match !== 1'b1) begin
      n_err++; $display("FAIL mid_restart got lat=%0d tbl=%h match=%b want 33 eb 1", lat, table_out, match);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unstable();
    int lat, bn, se;
    mode = 3;
    do_sweep(8'hEB, lat, bn, se);
    n_cmp++; if (unstable !== 8'h10) begin n_err++; $display("FAIL unst_flags got %h want 10", unstable); end
    n_cmp++; if (table_out !== 8'hEB) begin n_err++; $display("FAIL unst_table got %h want eb", table_out); end
    mode = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_small();
    int s, lat;
    lat = -1;
    expected2 = 4'h1;
    start2 = 1'b1;
    s = cyc;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      if (done2) begin lat = cyc - s; break; end
    end
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL small_latency got %0d want 9", lat); end
    n_cmp++; if (table_out2 !== 4'h1) begin n_err++; $display("FAIL small_table got %h want 1", table_out2); end
    n_cmp++; if (match2 !== 1'b1 || mismatch2 !== 4'h0) begin
      n_err++; $display("FAIL small_match got match=%b mis=%h want 1 0", match2, mismatch2);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    repeat (4) @(posedge clk);
    #1;
    test_eb_match();
    test_eb_mismatch();
    test_constants();
    test_reset_mid();
    test_unstable();
    test_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
